// File: rtl/isqrt_pipe_if.sv
// Operand/result bundle for the pipelined integer square root.
// The master drives operands and observes results; the slave is the datapath.
interface isqrt_pipe_if #(
  parameter int n_bits = 32
);
  localparam int r_bits = n_bits / 2;

  logic              in_vld;
  logic [n_bits-1:0] in_x;
  logic              out_vld;
  logic [r_bits-1:0] out_root;
  logic [r_bits:0]   out_rem;

  modport master (
    output in_vld, in_x,
    input  out_vld, out_root, out_rem
  );

  modport slave (
    input  in_vld, in_x,
    output out_vld, out_root, out_rem
  );
endinterface

// File: rtl/isqrt_pipe.sv
// Fully pipelined integer square root: one root bit per stage, r_bits stages,
// one operand accepted per clock, valid bit travelling alongside the data.
// Data registers load only behind a valid bit, so bubbles leave in-flight
// results untouched and the outputs hold the last valid result.
module isqrt_pipe #(
  parameter  int n_bits = 32,
  localparam int r_bits = n_bits / 2
) (
  input  logic         clk,
  input  logic         rst,
  isqrt_pipe_if.slave  io
);

  // Per-stage pipeline registers; index k is the output of stage k.
  logic              vld_q  [r_bits];
  logic [n_bits-1:0] rem_q  [r_bits];
  logic [n_bits-1:0] root_q [r_bits];

  for (genvar k = 0; k < r_bits; k++) begin : g_stage
    // Trial bit resolved by this stage: 4^(r_bits-1-k).
    localparam logic [n_bits-1:0] trial_bit = n_bits'(1) << (n_bits - 2 - 2*k);

    logic              en;
    logic [n_bits-1:0] rem_in;
    logic [n_bits-1:0] root_in;
    logic [n_bits-1:0] trial;
    logic [n_bits-1:0] rem_nx;
    logic [n_bits-1:0] root_nx;

    if (k == 0) begin : g_head
      assign en      = io.in_vld;
      assign rem_in  = io.in_x;
      assign root_in = '0;
    end else begin : g_body
      assign en      = vld_q[k-1];
      assign rem_in  = rem_q[k-1];
      assign root_in = root_q[k-1];
    end

    // One restoring step: subtract root+bit if it fits, and shift the root.
    always_comb begin
      // NOTE: every variable gets a default before the if, so no path leaves
      // one unassigned and no latch is inferred.
      trial   = root_in + trial_bit;
      rem_nx  = rem_in;
      root_nx = root_in >> 1;
      if (rem_in >= trial) begin
        rem_nx  = rem_in - trial;
        root_nx = (root_in >> 1) + trial_bit;
      end
    end

    // Valid shifts every cycle; data loads only behind a valid operand.
    always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every stage
      // samples its predecessor's pre-edge value, independent of block order.
      if (rst) begin
        // NOTE: the data registers are reset too (not just the valid bits),
        // because the outputs must read zero after reset, not stale data.
        vld_q[k]  <= 1'b0;
        rem_q[k]  <= '0;
        root_q[k] <= '0;
      end else begin
        vld_q[k] <= en;
        if (en) begin
          rem_q[k]  <= rem_nx;
          root_q[k] <= root_nx;
        end
      end
    end
  end

  // The final root fits in r_bits and the remainder in r_bits+1 (rem <= 2*root),
  // so the upper bits of the last stage are always zero.
  logic unused_hi;
  assign unused_hi = ^{rem_q[r_bits-1][n_bits-1:r_bits+1],
                       root_q[r_bits-1][n_bits-1:r_bits]};

  assign io.out_vld  = vld_q[r_bits-1];
  assign io.out_root = root_q[r_bits-1][r_bits-1:0];
  assign io.out_rem  = rem_q[r_bits-1][r_bits:0];

endmodule

// File: tb/tb_isqrt_pipe.sv
// Self-checking bench for isqrt_pipe: a 32-bit instance for directed and random
// traffic and an 8-bit instance swept exhaustively. A per-cycle monitor compares
// every output cycle against a queue-based reference model.
module tb_isqrt_pipe;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  isqrt_pipe_if #(.n_bits(32)) io32 ();
  isqrt_pipe_if #(.n_bits(8))  io8  ();

  isqrt_pipe #(.n_bits(32)) u_dut32 (.clk(clk), .rst(rst), .io(io32.slave));
  isqrt_pipe #(.n_bits(8))  u_dut8  (.clk(clk), .rst(rst), .io(io8.slave));

  typedef struct {
    int          due;
    logic [63:0] x;
  } item_t;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  int          rst_at  = -1;
  bit          mon_en  = 1'b0;
  item_t       q [2][$];
  logic [63:0] held_root [2];
  logic [63:0] held_rem  [2];

  // Count of rising edges seen so far.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d, expected %0d (edge %0d)", tag, obs, exp, cyc);
    end
  endtask

  // floor(sqrt(x)) by binary search on plain integers.
  function automatic logic [63:0] ref_isqrt(input logic [63:0] x);
    logic [63:0] lo = 0;
    logic [63:0] hi = 64'd65536;
    logic [63:0] mid;
    while (hi - lo > 1) begin
      mid = (lo + hi) / 2;
      if (mid * mid <= x) lo = mid;
      else                hi = mid;
    end
    return lo;
  endfunction

  // Compare one instance's outputs for the current cycle against the model.
  task automatic mon(input int d, input logic v, input logic [63:0] root, input logic [63:0] rem);
    item_t       it;
    logic [63:0] er;
    logic [63:0] erem;
    bit          exp_v;
    if (cyc == rst_at) begin
      held_root[d] = 0;
      held_rem[d]  = 0;
    end
    exp_v = (q[d].size() > 0) && (q[d][0].due == cyc);
    check(d == 0 ? "vld32" : "vld8", {63'd0, v}, {63'd0, exp_v});
    if (exp_v) begin
      it   = q[d].pop_front();
      er   = ref_isqrt(it.x);
      erem = it.x - er * er;
      check(d == 0 ? "root32" : "root8", root, er);
      check(d == 0 ? "rem32" : "rem8", rem, erem);
      check(d == 0 ? "recon32" : "recon8", root * root + rem, it.x);
      check(d == 0 ? "rem_bound32" : "rem_bound8", {63'd0, rem <= 2 * root}, 64'd1);
      held_root[d] = er;
      held_rem[d]  = erem;
    end else begin
      check(d == 0 ? "hold_root32" : "hold_root8", root, held_root[d]);
      check(d == 0 ? "hold_rem32" : "hold_rem8", rem, held_rem[d]);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      mon(0, io32.out_vld, 64'(io32.out_root), 64'(io32.out_rem));
      mon(1, io8.out_vld,  64'(io8.out_root),  64'(io8.out_rem));
    end
  end

  // Drive one cycle of inputs, record expectations, return at the next falling edge.
  task automatic step(input logic r, input logic v32 = 1'b0, input logic [31:0] x32 = '0,
                      input logic v8 = 1'b0, input logic [7:0] x8 = '0);
    rst         = r;
    io32.in_vld = v32;
    io32.in_x   = x32;
    io8.in_vld  = v8;
    io8.in_x    = x8;
    if (r) begin
      for (int d = 0; d < 2; d++)
        while (q[d].size() > 0 && q[d][$].due > cyc) void'(q[d].pop_back());
      rst_at = cyc + 1;
    end else begin
      if (v32) q[0].push_back('{cyc + 16, 64'(x32)});
      if (v8)  q[1].push_back('{cyc + 4,  64'(x8)});
    end
    @(negedge clk);
  endtask

  // Lone operand: result visible exactly one cycle, 16 edges after launch.
  task automatic single(input logic [31:0] x, input logic [63:0] er, input logic [63:0] erem);
    step(1'b0, 1'b1, x);
    repeat (15) step(1'b0);
    #1;
    check("single_vld", {63'd0, io32.out_vld}, 64'd1);
    check("single_root", 64'(io32.out_root), er);
    check("single_rem", 64'(io32.out_rem), erem);
    step(1'b0);
    #1;
    check("single_vld_after", {63'd0, io32.out_vld}, 64'd0);
  endtask

  logic        bub_v    [7] = '{1, 0, 0, 1, 1, 0, 1};
  logic [31:0] bub_x    [7] = '{100, 0, 0, 144, 2, 0, 99};
  logic [63:0] bub_root [7] = '{10, 10, 10, 12, 1, 1, 9};
  logic [63:0] bub_rem  [7] = '{0, 0, 0, 0, 1, 1, 18};

  initial begin
    held_root = '{0, 0};
    held_rem  = '{0, 0};
    io32.in_vld = 1'b0;
    io32.in_x   = '0;
    io8.in_vld  = 1'b0;
    io8.in_x    = '0;

    // Reset state.
    step(1'b1);
    step(1'b1);
    mon_en = 1'b1;
    #1;
    check("rst_vld", {63'd0, io32.out_vld}, 64'd0);
    check("rst_root", 64'(io32.out_root), 64'd0);
    check("rst_rem", 64'(io32.out_rem), 64'd0);

    // Isolated operands, including the maximum value.
    single(32'd0, 0, 0);
    single(32'd1, 1, 0);
    single(32'd15, 3, 6);
    single(32'd16, 4, 0);
    single(32'hFFFF_FFFF, 65535, 131070);

    // Bubble pattern: output valid pattern mirrors input, results hold through gaps.
    for (int i = 0; i < 7; i++) step(1'b0, bub_v[i], bub_x[i]);
    repeat (9) step(1'b0);
    for (int i = 0; i < 7; i++) begin
      #1;
      check("bub_vld", {63'd0, io32.out_vld}, {63'd0, bub_v[i]});
      check("bub_root", 64'(io32.out_root), bub_root[i]);
      check("bub_rem", 64'(io32.out_rem), bub_rem[i]);
      step(1'b0);
    end

    // Mid-flight reset: eight operands in flight, then one reset cycle.
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, $urandom());
    repeat (4) step(1'b0);
    step(1'b1, 1'b1, 32'd12345);
    for (int i = 0; i < 16; i++) begin
      #1;
      check("midrst_vld", {63'd0, io32.out_vld}, 64'd0);
      check("midrst_root", 64'(io32.out_root), 64'd0);
      check("midrst_rem", 64'(io32.out_rem), 64'd0);
      step(1'b0);
    end
    step(1'b0, 1'b1, 32'd49);
    repeat (15) step(1'b0);
    #1;
    check("post_rst_vld", {63'd0, io32.out_vld}, 64'd1);
    check("post_rst_root", 64'(io32.out_root), 64'd7);
    check("post_rst_rem", 64'(io32.out_rem), 64'd0);

    // Back-to-back random stream.
    for (int i = 0; i < 1000; i++) step(1'b0, 1'b1, $urandom());
    repeat (20) step(1'b0);

    // Exhaustive sweep of the 8-bit instance, back to back.
    for (int i = 0; i < 256; i++) step(1'b0, 1'b0, '0, 1'b1, 8'(i));
    repeat (10) step(1'b0);

    check("q32_drained", 64'(q[0].size()), 64'd0);
    check("q8_drained", 64'(q[1].size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/isqrt_pipe.md
Name: isqrt_pipe

Overview:
- Fully pipelined integer square root, one result bit resolved per stage, valid bit travelling alongside the data.
- Upstream stage of the sqrt-formula datapath. Its out_vld/out_root feed the valid-gated delay-alignment shift registers, which balance its latency against the parallel operand paths.
- Accepts one operand per clock, no backpressure.

Parameters:
- n_bits, 32, operand width. Must be even and >= 4.
- r_bits, n_bits/2, result width. Derived; do not override.

Ports:
- clk  in  1  clock, all state updates on posedge.
- rst  in  1  synchronous active-high reset.
- in_vld  in  1  in_x is a valid operand this cycle.
- in_x  in  n_bits  unsigned radicand.
- out_vld  out  1  out_root/out_rem carry a valid result this cycle.
- out_root  out  r_bits  floor(sqrt(x)).
- out_rem  out  r_bits+1  x - out_root^2. Range 0..2*out_root.

Behaviour:
- Reset: rst=1 at a posedge clears every stage's valid bit and data registers.
  - Next cycle: out_vld=0, out_root=0, out_rem=0.
  - rst has priority over in_vld in the same cycle; that operand is dropped.
- Latency: exactly r_bits cycles. in_vld=1 with in_x=X at posedge t gives out_vld=1 with the result of X after posedge t+r_bits-1, i.e. visible during cycle t+r_bits.
- Throughput: one operand per cycle. No stalls, no ready signal.
- Valid pipeline: an r_bits-deep chain of valid bits, shifted every cycle unconditionally.
- Data registers: stage k loads only when stage k-1's valid (or in_vld for stage 0) is 1; otherwise it holds.
  - Bubbles never corrupt in-flight results.
  - out_root/out_rem hold the last valid result while out_vld=0.
- Per-stage state: rem (n_bits), root (n_bits), with trial bit b_k = 1 << (n_bits-2-2k), a stage constant.
  - Stage 0 input: rem=in_x, root=0.
  - Stage k step:
    - t = root + b_k.
    - If rem >= t: rem_next = rem - t; root_next = (root >> 1) + b_k.
    - Else: rem_next = rem; root_next = root >> 1.
- Output mapping: out_root = root[r_bits-1:0] and out_rem = rem[r_bits:0], both from the final stage.
  - Upper bits are provably zero and are discarded.
- Arithmetic is unsigned throughout. Compare and subtract need no extra carry bit, because t <= 2^n_bits - 1 at every stage.
- Boundaries:
  - x=0 gives 0/0.
  - x = 2^n_bits-1 gives 2^r_bits-1 with rem 2^(r_bits+1)-2.
  - Perfect squares give rem=0.
- Mid-flight reset: all in-flight operands are discarded. No out_vld pulse appears in the cycles after reset until new in_vld operands have traversed r_bits stages.
- Invariant checked by the bench: whenever out_vld=1, out_root^2 + out_rem == the matching input and out_rem <= 2*out_root.

Test Plan:
- Single operands spaced > r_bits apart (n_bits=32), each checked with out_vld high exactly one cycle, 16 cycles after the in_vld cycle:
  - 0 -> root 0, rem 0.
  - 1 -> 1, 0.
  - 15 -> 3, 6.
  - 16 -> 4, 0.
- Max value: in_x=32'hFFFFFFFF -> out_root=65535, out_rem=131070.
- Back-to-back stream: 1000 consecutive random operands with in_vld held high -> 1000 consecutive out_vld cycles, in order, each matching a reference model.
- Bubbles: in_vld pattern 1,0,0,1,1,0,1 with operands 100,-,-,144,2,-,99 -> out_vld pattern identical, delayed 16 cycles; roots 10,12,1,9 and rems 0,0,1,18. out_root holds 10 through the bubble cycles.
- Reset mid-flight: launch 8 operands, assert rst for 1 cycle at the 5th -> out_vld stays 0 for 16 cycles after reset. Outputs read 0 until a new operand 49 launched after reset yields root 7, rem 0.
- Parameter sweep: n_bits=8, exhaustive 0..255 -> every result matches floor(sqrt) and the remainder invariant, with latency 4.
